// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_t    : fetch FSM states (RUN, HALTED, FAULT)
//   WORD_BYTES       : bytes per instruction word (PC increment)
//   RESET_PC_DEFAULT : default PC loaded on reset
package fetch_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      HALTED = 2'd1,
      FAULT  = 2'd2
   } fetch_state_t;

   localparam int          WORD_BYTES       = 4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program-counter register with next-PC mux.
//   clk, reset : clock and synchronous active-high reset (loads RESET_PC)
//   load       : take load_pc (redirect); has priority over advance
//   load_pc    : redirect byte target
//   advance    : step to pc + WORD_BYTES
//   pc         : current program counter
module pc_reg
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] load_pc,
   input  logic        advance,
   output logic [31:0] pc
);

   logic [31:0] pc_reg_q;
   logic [31:0] pc_next;

   // Wraps modulo 2^32; the range check upstream catches the wrap.
   always_comb begin
      pc_next = pc_reg_q;
      if (load)
         pc_next = load_pc;
      else if (advance)
         pc_next = pc_reg_q + 32'(WORD_BYTES);
   end

   always_ff @(posedge clk) begin
      if (reset)
         pc_reg_q <= RESET_PC;
      else
         pc_reg_q <= pc_next;
   end

   assign pc = pc_reg_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses imem, captures the word
// into an IF/ID register with valid/ready toward decode, applies redirects
// and parks in a sticky fault state on misaligned or out-of-range fetches.
//   clk, reset       : clock, synchronous active-high reset
//   imem_addr        : word address to imem (pc[ADDR_W+1:2])
//   imem_rd          : combinational read data from imem
//   redirect_valid/pc: taken branch/jump and its byte target
//   halt             : stop fetching, let the held output drain
//   out_valid/ready  : handshake toward decode
//   out_instr/out_pc : fetched instruction and its byte address
//   fault            : sticky fault flag
//   fetch_count      : saturating count of instructions loaded
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int          ADDR_W   = 6,
   parameter int          DEPTH    = 18,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rd,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   input  logic              halt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [31:0]       out_pc,
   output logic              fault,
   output logic [15:0]       fetch_count
);

   localparam logic [31:0] PC_LIMIT = 32'(WORD_BYTES * DEPTH);

   fetch_state_t state_reg;
   logic         out_valid_reg;
   logic [31:0]  out_instr_reg;
   logic [31:0]  out_pc_reg;
   logic         fault_reg;
   logic [15:0]  fetch_count_reg;
   logic [31:0]  pc;

   logic take_redirect;
   logic misaligned;
   logic out_of_range;
   logic do_fetch;
   logic drain;

   // FAULT ignores redirects entirely; RUN and HALTED both honour them.
   assign take_redirect = redirect_valid && (state_reg != FAULT);
   assign misaligned    = (redirect_pc[1:0] != 2'b00);
   assign out_of_range  = (pc >= PC_LIMIT);
   // Out-of-range and halt both suppress the fetch in the cycle they are seen.
   assign do_fetch      = (state_reg == RUN) && !redirect_valid && !out_of_range
                          && !halt && (!out_valid_reg || out_ready);
   assign drain         = out_valid_reg && out_ready;

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk     (clk),
      .reset   (reset),
      .load    (take_redirect),
      .load_pc (redirect_pc),
      .advance (do_fetch),
      .pc      (pc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= RUN;
         out_valid_reg   <= 1'b0;
         out_instr_reg   <= 32'h0;
         out_pc_reg      <= 32'h0;
         fault_reg       <= 1'b0;
         fetch_count_reg <= 16'h0;
      end else if (take_redirect) begin
         // Wrong-path flush regardless of out_ready.
         out_valid_reg <= 1'b0;
         if (misaligned) begin
            state_reg <= FAULT;
            fault_reg <= 1'b1;
         end else begin
            state_reg <= RUN;
         end
      end else begin
         if (do_fetch) begin
            out_instr_reg <= imem_rd;
            out_pc_reg    <= pc;
            out_valid_reg <= 1'b1;
            if (fetch_count_reg != 16'hFFFF)
               fetch_count_reg <= fetch_count_reg + 16'd1;
         end else if (drain) begin
            out_valid_reg <= 1'b0;
         end
         if (state_reg == RUN) begin
            if (out_of_range) begin
               state_reg <= FAULT;
               fault_reg <= 1'b1;
            end else if (halt) begin
               state_reg <= HALTED;
            end
         end
      end
   end

   assign imem_addr   = pc[ADDR_W+1:2];
   assign out_valid   = out_valid_reg;
   assign out_instr   = out_instr_reg;
   assign out_pc      = out_pc_reg;
   assign fault       = fault_reg;
   assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  imem_addr;
   logic [31:0] imem_rd;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        fault;
   logic [15:0] fetch_count;

   logic [31:0] mem [64];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign imem_rd = mem[imem_addr];

   fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .imem_addr      (imem_addr),
      .imem_rd        (imem_rd),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .fault          (fault),
      .fetch_count    (fetch_count)
   );

   // ---------------- behavioural reference ----------------
   // mode: 0 = fetching, 1 = halted, 2 = faulted
   int          m_mode;
   logic [31:0] m_pc;
   logic        m_valid;
   logic [31:0] m_instr;
   logic [31:0] m_opc;
   logic        m_fault;
   int          m_cnt;

   task automatic model_step(input logic rst, rv, input logic [31:0] rp,
                             input logic h, rdy);
      bit delivered;
      if (rst) begin
         m_mode = 0; m_pc = 0; m_valid = 0; m_instr = 0; m_opc = 0;
         m_fault = 0; m_cnt = 0;
         return;
      end
      delivered = m_valid && rdy;
      if (m_mode != 2 && rv) begin
         m_pc = rp;
         m_valid = 0;
         if (rp % 4 != 0) begin m_mode = 2; m_fault = 1; end
         else m_mode = 0;
      end else if (m_mode == 0 && m_pc >= 18 * 4) begin
         m_mode = 2; m_fault = 1;
         if (delivered) m_valid = 0;
      end else if (m_mode == 0 && h) begin
         m_mode = 1;
         if (delivered) m_valid = 0;
      end else if (m_mode == 0 && (!m_valid || rdy)) begin
         m_instr = mem[(m_pc / 4) % 64];
         m_opc   = m_pc;
         m_valid = 1;
         m_pc    = m_pc + 4;
         if (m_cnt < 65535) m_cnt++;
      end else if (delivered) begin
         m_valid = 0;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle(input logic rst, rv, input logic [31:0] rp,
                        input logic h, rdy);
      reset = rst; redirect_valid = rv; redirect_pc = rp; halt = h; out_ready = rdy;
      @(posedge clk);
      #1;
      model_step(rst, rv, rp, h, rdy);
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
         chk("out_pc", out_pc, m_opc);
         chk("out_instr", out_instr, m_instr);
      end
      chk("fault", 32'(fault), 32'(m_fault));
      chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
      chk("imem_addr", 32'(imem_addr), 32'(m_pc[7:2]));
      $display("t=%0t rst=%0b rv=%0b rp=%h h=%0b rdy=%0b | v=%0b pc=%h ins=%h f=%0b cnt=%0d",
               $time, rst, rv, rp, h, rdy, out_valid, out_pc, out_instr, fault, fetch_count);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic        rv;
      logic [31:0] rp;
      logic        h;
      logic        rdy;
      logic        ev;
      logic [31:0] epc;
      logic        ef;
   } vec_t;

   vec_t vecs [16];

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h2008_0001 + 32'(i);

      vecs[0]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h00, 1'b0};
      vecs[1]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h04, 1'b0};
      vecs[2]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h08, 1'b0};
      vecs[3]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h08, 1'b0};
      vecs[4]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h08, 1'b0};
      vecs[5]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h08, 1'b0};
      vecs[6]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h0C, 1'b0};
      vecs[7]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h10, 1'b0};
      vecs[8]  = '{1'b1, 32'h28, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0};
      vecs[9]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h28, 1'b0};
      vecs[10] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h2C, 1'b0};
      vecs[11] = '{1'b1, 32'h6,  1'b0, 1'b1, 1'b0, 32'h00, 1'b1};
      vecs[12] = '{1'b1, 32'h0,  1'b0, 1'b1, 1'b0, 32'h00, 1'b1};
      vecs[13] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h00, 1'b1};
      vecs[14] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h00, 1'b1};
      vecs[15] = '{1'b1, 32'h8,  1'b1, 1'b1, 1'b0, 32'h00, 1'b1};

      // reset state
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 1);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_fault", 32'(fault), 32'h0);
      chk("rst_count", 32'(fetch_count), 32'h0);
      chk("rst_out_pc", out_pc, 32'h0);
      chk("rst_out_instr", out_instr, 32'h0);
      chk("rst_addr", 32'(imem_addr), 32'h0);

      for (int i = 0; i < 16; i++) begin
         cycle(0, vecs[i].rv, vecs[i].rp, vecs[i].h, vecs[i].rdy);
         chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
         if (vecs[i].ev) begin
            chk($sformatf("vec%0d_pc", i), out_pc, vecs[i].epc);
            chk($sformatf("vec%0d_instr", i), out_instr, 32'h2008_0001 + (vecs[i].epc >> 2));
         end
         chk($sformatf("vec%0d_fault", i), 32'(fault), 32'(vecs[i].ef));
         if (i == 5) chk("stall_addr", 32'(imem_addr), 32'd3);
         if (i == 7) chk("count5", 32'(fetch_count), 32'd5);
      end

      // run off the end of the program
      cycle(1, 0, 0, 0, 1);
      for (int i = 0; i < 18; i++) cycle(0, 0, 0, 0, 1);
      chk("end_last_pc", out_pc, 32'h44);
      chk("end_last_valid", 32'(out_valid), 32'h1);
      chk("end_no_fault", 32'(fault), 32'h0);
      cycle(0, 0, 0, 0, 1);
      chk("end_fault", 32'(fault), 32'h1);
      chk("end_drained", 32'(out_valid), 32'h0);
      cycle(1, 0, 0, 0, 1);
      chk("end_rst_fault", 32'(fault), 32'h0);
      chk("end_rst_addr", 32'(imem_addr), 32'h0);

      // halt with pc 4 held, then restart by redirect
      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 1);
      chk("halt_pre_pc", out_pc, 32'h4);
      cycle(0, 0, 0, 1, 0);
      chk("halt_held", 32'(out_valid), 32'h1);
      chk("halt_held_pc", out_pc, 32'h4);
      cycle(0, 0, 0, 0, 1);
      chk("halt_drained", 32'(out_valid), 32'h0);
      cycle(0, 0, 0, 0, 1);
      chk("halt_stays", 32'(out_valid), 32'h0);
      cycle(0, 1, 32'h10, 0, 1);
      chk("halt_bubble", 32'(out_valid), 32'h0);
      cycle(0, 0, 0, 0, 1);
      chk("halt_target_pc", out_pc, 32'h10);
      chk("halt_target_valid", 32'(out_valid), 32'h1);

      // randomized traffic against the reference
      for (int i = 0; i < 1500; i++) begin
         logic        rst, rv, h, rdy;
         logic [31:0] rp;
         rst = ($urandom_range(99) < 2);
         rv  = ($urandom_range(99) < 10);
         if ($urandom_range(9) == 0) rp = $urandom;
         else rp = 32'($urandom_range(20)) << 2;
         h   = ($urandom_range(99) < 5);
         rdy = ($urandom_range(99) < 70);
         cycle(rst, rv, rp, h, rdy);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
